// File: rtl/uart_8n1_pkg.sv
// Shared constants and receiver state encoding for the 8N1 UART on the 16x baud clock.
package uart_8n1_pkg;

    localparam int         OVERSAMPLE     = 16;
    localparam logic [3:0] SAMPLE_TICK_LO  = 4'd7;
    localparam logic [3:0] SAMPLE_TICK_MID = 4'd8;
    localparam logic [3:0] SAMPLE_TICK_HI  = 4'd9;
    localparam logic [3:0] LAST_TICK       = 4'(OVERSAMPLE - 1);
    localparam int         DATA_BITS       = 8;
    localparam logic [3:0] LAST_DATA_IDX   = 4'(DATA_BITS);
    localparam logic [3:0] STOP_IDX        = 4'd9;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_IDLE
    } rx_state_e;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-flop synchronizer for the asynchronous rx line; resets to the idle (high) level.
module uart_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_8n1_receiver.sv
// 8N1 UART receiver: 16x oversampling, 3-sample majority vote, one-deep holding register.
//
//  state        | meaning
//  RX_IDLE      | line idle, waiting for rx_s low (tick 0 of start bit)
//  RX_START     | validating start bit; majority high at tick 9 rejects a glitch
//  RX_DATA      | shifting 8 data bits LSB first, sampled at tick 9
//  RX_STOP      | stop bit decision at tick 9: load byte or flag framing error
//  RX_WAIT_IDLE | after a framing error, wait for the line to return high
module uart_8n1_receiver
    import uart_8n1_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk_baud_16x_i,
    input  logic       reset_i,
    input  logic       rx_i,
    output logic [7:0] recv_data_o,
    output logic       recv_valid_o,
    input  logic       recv_read_i,
    output logic       recv_overrun_o,
    output logic       recv_frame_err_o,
    output logic       recv_busy_o
);

    logic                 rx_s;
    rx_state_e            state_q, state_d;
    logic [3:0]           tick_q, tick_d;
    logic [3:0]           bit_idx_q, bit_idx_d;
    logic [1:0]           samp_q, samp_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 overrun_q, overrun_d;
    logic                 frame_err_q, frame_err_d;
    logic                 load;
    logic                 maj;

    uart_rx_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk_i  (clk_baud_16x_i),
        .reset_i(reset_i),
        .d_i    (rx_i),
        .q_o    (rx_s)
    );

    always_ff @(posedge clk_baud_16x_i) begin
        if (reset_i) begin
            state_q     <= RX_IDLE;
            tick_q      <= '0;
            bit_idx_q   <= '0;
            samp_q      <= '1;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_q      <= tick_d;
            bit_idx_q   <= bit_idx_d;
            samp_q      <= samp_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        tick_d      = tick_q + 4'd1;
        bit_idx_d   = bit_idx_q;
        samp_d      = samp_q;
        shift_d     = shift_q;
        frame_err_d = 1'b0;
        load        = 1'b0;
        maj         = majority3(samp_q[1], samp_q[0], rx_s);

        if (tick_q == LAST_TICK) begin
            bit_idx_d = bit_idx_q + 4'd1;
        end
        if (tick_q == SAMPLE_TICK_LO) begin
            samp_d[1] = rx_s;
        end
        if (tick_q == SAMPLE_TICK_MID) begin
            samp_d[0] = rx_s;
        end

        case (state_q)
            RX_IDLE: begin
                tick_d    = '0;
                bit_idx_d = '0;
                if (!rx_s) begin
                    state_d = RX_START;
                    tick_d  = 4'd1;
                end
            end
            RX_START: begin
                if (tick_q == SAMPLE_TICK_HI && maj) begin
                    state_d = RX_IDLE;
                end else if (tick_q == LAST_TICK) begin
                    state_d = RX_DATA;
                end
            end
            RX_DATA: begin
                if (tick_q == SAMPLE_TICK_HI) begin
                    shift_d = {maj, shift_q[DATA_BITS-1:1]};
                end
                if (tick_q == LAST_TICK && bit_idx_q == LAST_DATA_IDX) begin
                    state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (tick_q == SAMPLE_TICK_HI && bit_idx_q == STOP_IDX) begin
                    if (maj) begin
                        load    = 1'b1;
                        state_d = RX_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = RX_WAIT_IDLE;
                    end
                end
            end
            RX_WAIT_IDLE: begin
                tick_d    = '0;
                bit_idx_d = '0;
                if (rx_s) begin
                    state_d = RX_IDLE;
                end
            end
            default: begin
                state_d   = RX_IDLE;
                tick_d    = '0;
                bit_idx_d = '0;
            end
        endcase
    end

    // Holding register: a read in the load cycle makes room for the new byte.
    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        if (load) begin
            if (!valid_q) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else if (recv_read_i) begin
                data_d    = shift_q;
                overrun_d = 1'b0;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (recv_read_i && valid_q) begin
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end
    end

    assign recv_data_o      = data_q;
    assign recv_valid_o     = valid_q;
    assign recv_overrun_o   = overrun_q;
    assign recv_frame_err_o = frame_err_q;
    assign recv_busy_o      = (state_q != RX_IDLE);

endmodule

// File: tb/tb_uart_8n1_receiver.sv
// Directed bench for uart_8n1_receiver: bit-banged frames on the 16x clock, hand-computed expectations.
module tb_uart_8n1_receiver;

    localparam int CLK_PERIOD = 4;
    localparam int FRAME_CYC  = 160;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx = 1'b1;
    logic       recv_read = 1'b0;
    logic [7:0] recv_data;
    logic       recv_valid;
    logic       recv_overrun;
    logic       recv_frame_err;
    logic       recv_busy;

    int n_checks = 0;
    int n_fail   = 0;
    int err_cnt  = 0;
    logic busy_seen;

    always #(CLK_PERIOD / 2) clk = ~clk;

    uart_8n1_receiver #(.SYNC_STAGES(2)) dut (
        .clk_baud_16x_i  (clk),
        .reset_i         (reset),
        .rx_i            (rx),
        .recv_data_o     (recv_data),
        .recv_valid_o    (recv_valid),
        .recv_read_i     (recv_read),
        .recv_overrun_o  (recv_overrun),
        .recv_frame_err_o(recv_frame_err),
        .recv_busy_o     (recv_busy)
    );

    always @(posedge clk) begin
        if (recv_frame_err === 1'b1) err_cnt <= err_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Call on a negedge; drives the first ncyc cycles of a frame, 16 cycles per bit.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int ncyc);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < ncyc; i++) begin
            rx = f[i / 16];
            @(negedge clk);
        end
    endtask

    task automatic pulse_read();
        @(negedge clk);
        recv_read = 1'b1;
        @(negedge clk);
        recv_read = 1'b0;
    endtask

    initial begin
        // 1: reset and idle
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_data", recv_data, 8'h00);
        check("rst_valid", recv_valid, 0);
        check("rst_overrun", recv_overrun, 0);
        check("rst_frame_err", recv_frame_err, 0);
        check("rst_busy", recv_busy, 0);
        busy_seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (recv_busy !== 1'b0) busy_seen = 1'b1;
        end
        check("idle_busy_100", busy_seen, 0);

        // 2: single frame, exact latency, read clears
        fork
            send_frame(8'h42, 1'b1, FRAME_CYC);
            begin
                repeat (155) @(posedge clk);
                #1 check("lat_valid_early", recv_valid, 0);
                @(posedge clk);
                #1 check("lat_valid_156", recv_valid, 1);
                check("lat_data_42", recv_data, 8'h42);
                check("lat_busy_after_stop", recv_busy, 0);
            end
        join
        @(negedge clk);
        recv_read = 1'b1;
        @(posedge clk);
        #1 check("read_clears_valid", recv_valid, 0);
        @(negedge clk);
        recv_read = 1'b0;

        // 3a: back-to-back frames without reading -> overrun, first byte kept
        send_frame(8'h42, 1'b1, FRAME_CYC);
        send_frame(8'hCA, 1'b1, FRAME_CYC);
        repeat (10) @(negedge clk);
        check("ovr_data_kept", recv_data, 8'h42);
        check("ovr_valid", recv_valid, 1);
        check("ovr_flag", recv_overrun, 1);
        pulse_read();
        check("ovr_read_valid", recv_valid, 0);
        check("ovr_read_flag", recv_overrun, 0);

        // 3b: read coinciding with the second load cycle
        send_frame(8'h42, 1'b1, FRAME_CYC);
        check("rl_first_data", recv_data, 8'h42);
        fork
            send_frame(8'hCA, 1'b1, FRAME_CYC);
            begin
                repeat (155) @(posedge clk);
                @(negedge clk);
                recv_read = 1'b1;
                @(posedge clk);
                #1 recv_read = 1'b0;
                check("rl_data_ca", recv_data, 8'hCA);
                check("rl_valid", recv_valid, 1);
                check("rl_overrun", recv_overrun, 0);
            end
        join
        pulse_read();
        check("rl_read_valid", recv_valid, 0);

        // 4: short glitch rejected
        repeat (20) @(negedge clk);
        rx = 1'b0;
        repeat (4) @(posedge clk);
        #1 check("glitch_busy_high", recv_busy, 1);
        @(negedge clk);
        rx = 1'b1;
        repeat (9) @(posedge clk);
        #1 check("glitch_busy_by_tick10", recv_busy, 0);
        repeat (200) @(negedge clk);
        check("glitch_no_valid", recv_valid, 0);
        check("glitch_no_ferr", err_cnt, 0);
        check("glitch_no_overrun", recv_overrun, 0);

        // 5: framing error followed by a break
        fork
            send_frame(8'h55, 1'b0, FRAME_CYC);
            begin
                repeat (156) @(posedge clk);
                #1 check("ferr_pulse", recv_frame_err, 1);
                check("ferr_valid", recv_valid, 0);
                @(posedge clk);
                #1 check("ferr_one_cycle", recv_frame_err, 0);
            end
        join
        repeat (40) @(negedge clk);
        check("ferr_busy_in_break", recv_busy, 1);
        check("ferr_no_retrigger", err_cnt, 1);
        rx = 1'b1;
        repeat (4) @(posedge clk);
        #1 check("ferr_busy_released", recv_busy, 0);
        check("ferr_valid_after", recv_valid, 0);

        // 6: reset mid-frame, then a clean frame
        repeat (20) @(negedge clk);
        send_frame(8'h3C, 1'b1, FRAME_CYC);
        send_frame(8'h81, 1'b1, FRAME_CYC);
        check("pre_rst_overrun", recv_overrun, 1);
        send_frame(8'h42, 1'b1, 56);
        check("pre_rst_busy", recv_busy, 1);
        reset = 1'b1;
        rx    = 1'b1;
        @(posedge clk);
        #1 check("mid_rst_data", recv_data, 8'h00);
        check("mid_rst_valid", recv_valid, 0);
        check("mid_rst_overrun", recv_overrun, 0);
        check("mid_rst_busy", recv_busy, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        send_frame(8'hCA, 1'b1, FRAME_CYC);
        repeat (10) @(negedge clk);
        check("post_rst_data", recv_data, 8'hCA);
        check("post_rst_valid", recv_valid, 1);
        check("post_rst_overrun", recv_overrun, 0);
        check("post_rst_ferr_cnt", err_cnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
